// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through D-cache; load hit data one cycle after the unstalled cycle, miss refills 4 words.
// Stall is combinational; memory side is a valid/ready request channel with one request outstanding.
module dcache_ctrl #(
   parameter int INDEX_BITS = 6
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_re,
   input  logic [3:0]  cpu_we,
   input  logic [31:0] cpu_din,
   input  logic        inv,
   output logic [31:0] cpu_dout,
   output logic        stall,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_rnw,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_data,
   output logic [3:0]  mem_req_mask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
);

   localparam int LINES  = 1 << INDEX_BITS;
   localparam int TAG_W  = 28 - INDEX_BITS;
   localparam int WORDS  = LINES * 4;
   localparam int AW     = INDEX_BITS + 2;

   typedef enum logic [1:0] {IDLE, WRITE, FILL_REQ, FILL_WAIT} state_t;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } wbuf_t;

   state_t                         state_q, state_d;
   logic [LINES-1:0]               valid_q, valid_d;
   logic [LINES-1:0][TAG_W-1:0]    tag_q, tag_d;
   logic [1:0]                     cnt_q, cnt_d;
   logic [TAG_W+INDEX_BITS-1:0]    fill_line_q, fill_line_d;
   wbuf_t                          wbuf_q, wbuf_d;
   logic [31:0]                    rdata_q;

   logic [31:0] data_arr [WORDS];
   logic [3:0]  arr_we;
   logic [AW-1:0] arr_waddr;
   logic [31:0] arr_wdata;
   logic        rd_en;

   logic [TAG_W-1:0]      req_tag;
   logic [INDEX_BITS-1:0] req_idx;
   logic [1:0]            req_word;
   logic [INDEX_BITS-1:0] fill_idx;
   logic [TAG_W-1:0]      fill_tag;
   logic                  hit;
   logic                  unused_addr_bits;

   assign req_tag          = cpu_addr[31:4+INDEX_BITS];
   assign req_idx          = cpu_addr[4+INDEX_BITS-1:4];
   assign req_word         = cpu_addr[3:2];
   assign unused_addr_bits = ^cpu_addr[1:0];
   assign fill_idx         = fill_line_q[INDEX_BITS-1:0];
   assign fill_tag         = fill_line_q[TAG_W+INDEX_BITS-1:INDEX_BITS];
   assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign cpu_dout         = reset ? 32'h0 : rdata_q;

   always_comb begin
      state_d       = state_q;
      valid_d       = valid_q;
      tag_d         = tag_q;
      cnt_d         = cnt_q;
      fill_line_d   = fill_line_q;
      wbuf_d        = wbuf_q;
      stall         = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_rnw   = 1'b0;
      mem_req_addr  = 32'h0;
      mem_req_data  = 32'h0;
      mem_req_mask  = 4'h0;
      arr_we        = 4'h0;
      arr_waddr     = {req_idx, req_word};
      arr_wdata     = cpu_din;
      rd_en         = 1'b0;

      case (state_q)
         IDLE: begin
            if (inv) begin
               valid_d = '0;
               stall   = 1'b1;
            end else if (cpu_we != 4'h0) begin
               if (hit) arr_we = cpu_we;
               wbuf_d  = '{addr: cpu_addr[31:2], data: cpu_din, mask: cpu_we};
               state_d = WRITE;
            end else if (cpu_re) begin
               if (hit) begin
                  rd_en = 1'b1;
               end else begin
                  // Drop the victim line now so a half-written line can never hit.
                  stall            = 1'b1;
                  cnt_d            = 2'd0;
                  valid_d[req_idx] = 1'b0;
                  fill_line_d      = cpu_addr[31:4];
                  state_d          = FILL_REQ;
               end
            end
         end
         WRITE: begin
            stall         = cpu_re | (|cpu_we);
            mem_req_valid = 1'b1;
            mem_req_addr  = {wbuf_q.addr, 2'b00};
            mem_req_data  = wbuf_q.data;
            mem_req_mask  = wbuf_q.mask;
            if (mem_req_ready) state_d = IDLE;
         end
         FILL_REQ: begin
            stall         = 1'b1;
            mem_req_valid = 1'b1;
            mem_req_rnw   = 1'b1;
            mem_req_addr  = {fill_line_q, cnt_q, 2'b00};
            if (mem_req_ready) state_d = FILL_WAIT;
         end
         FILL_WAIT: begin
            stall = 1'b1;
            if (mem_resp_valid) begin
               arr_we    = 4'hF;
               arr_waddr = {fill_idx, cnt_q};
               arr_wdata = mem_resp_data;
               if (cnt_q == 2'd3) begin
                  valid_d[fill_idx] = 1'b1;
                  tag_d[fill_idx]   = fill_tag;
                  cnt_d             = 2'd0;
                  state_d           = IDLE;
               end else begin
                  cnt_d   = cnt_q + 2'd1;
                  state_d = FILL_REQ;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (reset) begin
         stall         = 1'b0;
         mem_req_valid = 1'b0;
         arr_we        = 4'h0;
         rd_en         = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         tag_q       <= '0;
         cnt_q       <= 2'd0;
         fill_line_q <= '0;
         wbuf_q      <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         tag_q       <= tag_d;
         cnt_q       <= cnt_d;
         fill_line_q <= fill_line_d;
         wbuf_q      <= wbuf_d;
      end
   end

   // Data array keeps its contents across reset; only the tags/valid bits are cleared.
   always_ff @(posedge CLK) begin
      for (int b = 0; b < 4; b++) begin
         if (arr_we[b]) data_arr[arr_waddr][8*b +: 8] <= arr_wdata[8*b +: 8];
      end
   end

   always_ff @(posedge CLK) begin
      if (reset)      rdata_q <= 32'h0;
      else if (rd_en) rdata_q <= data_arr[{req_idx, req_word}];
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, reset-during-fill sequence,
// and randomized traffic checked against a line-level cache/memory reference model.
module tb_dcache_ctrl;

   logic        CLK = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic        cpu_re;
   logic [3:0]  cpu_we;
   logic [31:0] cpu_din;
   logic        inv;
   logic [31:0] cpu_dout;
   logic        stall;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_rnw;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic [3:0]  mem_req_mask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   always #5 CLK = ~CLK;

   dcache_ctrl #(.INDEX_BITS(6)) dut (
      .CLK(CLK), .reset(reset), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
      .cpu_din(cpu_din), .inv(inv), .cpu_dout(cpu_dout), .stall(stall),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   // Memory as seen by the DUT, and the golden image the CPU program implies.
   logic [31:0] mem  [logic [31:0]];
   logic [31:0] gold [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] gold_rd(input logic [31:0] a);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      if (gold.exists(k)) return gold[k];
      return init_word(k);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m, input logic [31:0] d);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic gold_wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      gold[k] = merge(gold_rd(k), m, d);
   endtask

   // Memory responder: ready after ready_delay wait cycles, read data one cycle after accept.
   typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] mask; } wr_t;
   int          ready_delay = 0;
   int          wait_cnt    = 0;
   int          rd_hs_total = 0;
   bit          hs_prev     = 0;
   logic        hs_rnw;
   logic [31:0] hs_addr, hs_data;
   logic [3:0]  hs_mask;
   logic [31:0] rd_log [$];
   wr_t         wr_log [$];

   initial begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      forever begin
         @(posedge CLK);
         #2;
         mem_resp_valid = 1'b0;
         if (hs_prev) begin
            if (hs_rnw) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = mem_rd(hs_addr);
            end else begin
               mem[hs_addr] = merge(mem_rd(hs_addr), hs_mask, hs_data);
               wr_log.push_back('{hs_addr, hs_data, hs_mask});
            end
            hs_prev = 0;
         end
         mem_req_ready = 1'b0;
         if (mem_req_valid) begin
            if (wait_cnt >= ready_delay) begin
               mem_req_ready = 1'b1;
               hs_prev  = 1;
               hs_rnw   = mem_req_rnw;
               hs_addr  = mem_req_addr;
               hs_data  = mem_req_data;
               hs_mask  = mem_req_mask;
               wait_cnt = 0;
               check32("req addr alignment", {30'h0, mem_req_addr[1:0]}, 32'h0);
               if (mem_req_rnw) begin
                  rd_hs_total++;
                  rd_log.push_back(mem_req_addr);
               end
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // op: 0 load, 1 store, 2 invalidate (with a simultaneous load to prove inv wins).
   task automatic cpu_op(input int op, input logic [31:0] addr, input logic [3:0] we,
                         input logic [31:0] din, output int stalls, output logic [31:0] dout);
      cpu_addr = addr;
      cpu_re   = (op == 0 || op == 2);
      cpu_we   = (op == 1) ? we : 4'h0;
      cpu_din  = din;
      inv      = (op == 2);
      stalls   = 0;
      @(negedge CLK);
      if (op == 2) begin
         if (stall) stalls = 1;
      end else begin
         while (stall && stalls < 300) begin
            stalls++;
            @(negedge CLK);
         end
      end
      @(posedge CLK);
      #1;
      dout   = cpu_dout;
      cpu_re = 1'b0;
      cpu_we = 4'h0;
      inv    = 1'b0;
   endtask

   typedef struct {
      int          op;
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] din;
      int          rdly;
      int          exp_stall;
      int          exp_reads;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vec [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w104, w108, w2000, dout, rd0_addr;
      logic [21:0] tags [4];
      logic [21:0] mline [int];
      int          stalls, rd0, idx, op, exp_stall, exp_reads, exp_rd_total, cycles;
      logic [21:0] tag;
      logic [31:0] addr;
      logic [3:0]  we;
      bit          wr_pending, is_hit;

      w104  = init_word(32'h104);
      w108  = init_word(32'h108);
      w2000 = init_word(32'h2000);
      vec[0] = '{0, 32'h0000_0104, 4'h0, 32'h0, 0, 9, 4, w104};
      vec[1] = '{0, 32'h0000_0108, 4'h0, 32'h0, 0, 0, 0, w108};
      vec[2] = '{1, 32'h0000_0104, 4'b0011, 32'h0000_BEEF, 3, 0, 0, 32'h0};
      vec[3] = '{0, 32'h0000_0104, 4'h0, 32'h0, 3, 4, 0, {w104[31:16], 16'hBEEF}};
      vec[4] = '{1, 32'h0000_2000, 4'b1100, 32'hABCD_0000, 0, 0, 0, 32'h0};
      vec[5] = '{0, 32'h0000_2000, 4'h0, 32'h0, 0, 10, 4, {16'hABCD, w2000[15:0]}};
      vec[6] = '{2, 32'h0000_0108, 4'h0, 32'h0, 0, 1, 0, 32'h0};
      vec[7] = '{0, 32'h0000_0104, 4'h0, 32'h0, 0, 9, 4, {w104[31:16], 16'hBEEF}};
      vec[8] = '{0, 32'h0000_0108, 4'h0, 32'h0, 0, 0, 0, w108};
      vec[9] = '{0, 32'h0000_010B, 4'h0, 32'h0, 0, 0, 0, w108};
      tags = '{22'h0, 22'h1, 22'h3F_FFFF, 22'h2A_AAAA};

      // Reset, with a load already requested to show reset dominates.
      reset = 1'b1; cpu_addr = 32'h104; cpu_re = 1'b1; cpu_we = 4'h0; cpu_din = 32'h0; inv = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check32("reset stall", {31'h0, stall}, 32'h0);
      check32("reset mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
      check32("reset cpu_dout", cpu_dout, 32'h0);
      reset  = 1'b0;
      cpu_re = 1'b0;
      @(posedge CLK);
      #1;

      for (int i = 0; i < 10; i++) begin
         ready_delay = vec[i].rdly;
         rd0 = rd_hs_total;
         cpu_op(vec[i].op, vec[i].addr, vec[i].we, vec[i].din, stalls, dout);
         if (vec[i].op == 1) gold_wr(vec[i].addr, vec[i].we, vec[i].din);
         check32($sformatf("vec%0d stall cycles", i), 32'(stalls), 32'(vec[i].exp_stall));
         check32($sformatf("vec%0d memory reads", i), 32'(rd_hs_total - rd0), 32'(vec[i].exp_reads));
         if (vec[i].op == 0) check32($sformatf("vec%0d cpu_dout", i), dout, vec[i].exp_dout);
         if (i == 0) begin
            for (int k = 0; k < 4; k++) begin
               rd0_addr = (rd_log.size() > k) ? rd_log[k] : 32'hFFFF_FFFF;
               check32($sformatf("fill order word%0d", k), rd0_addr, 32'h100 + 32'(4 * k));
            end
         end
      end
      check32("write count", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() >= 2) begin
         check32("wr0 addr", wr_log[0].addr, 32'h104);
         check32("wr0 data", wr_log[0].data, 32'h0000_BEEF);
         check32("wr0 mask", {28'h0, wr_log[0].mask}, 32'h3);
         check32("wr1 addr", wr_log[1].addr, 32'h2000);
         check32("wr1 mask", {28'h0, wr_log[1].mask}, 32'hC);
      end

      // Reset while the third fill response is due: line must stay invalid.
      ready_delay = 0;
      rd0 = rd_hs_total;
      cpu_addr = 32'h504; cpu_re = 1'b1;
      cycles = 0;
      while (rd_hs_total < rd0 + 3 && cycles < 100) begin
         @(posedge CLK);
         #1;
         cycles++;
      end
      check32("reset-test fill progress", 32'(rd_hs_total - rd0), 32'd3);
      reset = 1'b1; cpu_re = 1'b0;
      @(posedge CLK);
      #1;
      check32("mid-fill reset stall", {31'h0, stall}, 32'h0);
      check32("mid-fill reset mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
      check32("mid-fill reset cpu_dout", cpu_dout, 32'h0);
      reset = 1'b0;
      rd0 = rd_hs_total;
      cpu_op(0, 32'h104, 4'h0, 32'h0, stalls, dout);
      check32("post-reset load stall", 32'(stalls), 32'd9);
      check32("post-reset load reads", 32'(rd_hs_total - rd0), 32'd4);
      check32("post-reset load data", dout, gold_rd(32'h104));

      // Randomized traffic against the reference model.
      cpu_op(2, 32'h0, 4'h0, 32'h0, stalls, dout);
      check32("random-phase inv stall", 32'(stalls), 32'd1);
      wr_pending   = 0;
      exp_rd_total = 0;
      rd0 = rd_hs_total;
      for (int n = 0; n < 200; n++) begin
         op = $urandom_range(0, 99);
         op = (op < 50) ? 0 : (op < 85) ? 1 : 2;
         if (op == 2 && wr_pending) op = 0;
         if (!wr_pending) ready_delay = $urandom_range(0, 2);
         tag  = tags[$urandom_range(0, 3)];
         idx  = $urandom_range(0, 3);
         addr = {tag, 6'(idx), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         we   = (op == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         is_hit    = mline.exists(idx) && (mline[idx] == tag);
         exp_stall = (wr_pending && op != 2) ? ready_delay + 1 : 0;
         exp_reads = 0;
         if (op == 2) exp_stall = 1;
         if (op == 0 && !is_hit) begin
            exp_stall += 1 + 4 * (ready_delay + 2);
            exp_reads = 4;
         end
         exp_rd_total += exp_reads;
         cpu_op(op, addr, we, $urandom, stalls, dout);
         check32($sformatf("rand%0d op%0d stall", n, op), 32'(stalls), 32'(exp_stall));
         if (op == 0) begin
            check32($sformatf("rand%0d load %h", n, addr), dout, gold_rd(addr));
            if (!is_hit) mline[idx] = tag;
            wr_pending = 0;
         end else if (op == 1) begin
            gold_wr(addr, we, cpu_din);
            wr_pending = 1;
         end else begin
            mline.delete();
         end
      end
      repeat (8) @(posedge CLK);
      #1;
      check32("random reads total", 32'(rd_hs_total - rd0), 32'(exp_rd_total));
      foreach (gold[k]) check32($sformatf("memory image %h", k), mem_rd(k), gold[k]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
